// File: rtl/width_fifo_pkg.sv
// Shared defaults and elaboration helpers for the elastic width FIFO.
package width_fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/width_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module width_fifo_mem
    import width_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Contents are deliberately not reset; the stage masks the output when empty.
    logic [WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/width_fifo_stage.sv
// Elastic valid/ready FIFO stage with first-word-fall-through output, occupancy and sticky drop flag.
module width_fifo_stage
    import width_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic [AW:0]      count,
    output logic             drop_seen
);

    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    generate
        if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_depth_check
            $error("width_fifo_stage: DEPTH must be a power of two, 2 or more");
        end
        if (WIDTH < 1) begin : g_width_check
            $error("width_fifo_stage: WIDTH must be 1 or more");
        end
    endgenerate

    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [AW:0]      count_reg, count_next;
    logic             drop_seen_reg, drop_seen_next;
    logic             push, pop;
    logic             mem_we;
    logic [WIDTH-1:0] mem_rdata;

    // Ready depends only on registered occupancy: no combinational path from out_ready.
    assign in_ready  = (count_reg != FULL_COUNT);
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign mem_we    = push && !flush;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        drop_seen_next = drop_seen_reg || (in_valid && !in_ready);
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_ONE;
                2'b01:   count_next = count_reg - CNT_ONE;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            drop_seen_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            drop_seen_reg <= drop_seen_next;
        end
    end

    width_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_reg),
        .wdata (data_in),
        .raddr (rd_ptr_reg),
        .rdata (mem_rdata)
    );

    // Masking keeps the output deterministic and never exposes unwritten storage.
    assign data_out  = out_valid ? mem_rdata : '0;
    assign count     = count_reg;
    assign drop_seen = drop_seen_reg;

endmodule

// File: tb/tb_width_fifo_stage.sv
// Self-checking bench: directed table, corner-case sequences and a queue-model random run.
module tb_width_fifo_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush, in_valid, out_ready;
    logic [7:0] data_in;
    logic       in_ready, out_valid, drop_seen;
    logic [7:0] data_out;
    logic [2:0] count;

    logic        flush16, in_valid16, out_ready16;
    logic [15:0] data_in16;
    logic        in_ready16, out_valid16, drop_seen16;
    logic [15:0] data_out16;
    logic [2:0]  count16;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    width_fifo_stage #(.WIDTH(8), .DEPTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .count(count), .drop_seen(drop_seen)
    );

    width_fifo_stage #(.WIDTH(16), .DEPTH(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .flush(flush16),
        .in_valid(in_valid16), .in_ready(in_ready16), .data_in(data_in16),
        .out_valid(out_valid16), .out_ready(out_ready16), .data_out(data_out16),
        .count(count16), .drop_seen(drop_seen16)
    );

    typedef struct {
        logic       fl;
        logic       iv;
        logic [7:0] d;
        logic       ord;
        int         cnt;
        logic       ov;
        logic       ir;
        logic [7:0] dout;
        logic       drop;
    } vec_t;

    vec_t tbl[11];

    // Behavioural model: contents as a queue plus a sticky flag.
    logic [7:0] model_q[$];
    logic       model_drop;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input int cnt, input logic ov, input logic ir,
                              input logic [7:0] dout, input logic drop);
        chk({tag, ".count"},     32'(count),     32'(cnt));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
        chk({tag, ".data_out"},  32'(data_out),  32'(dout));
        chk({tag, ".drop_seen"}, 32'(drop_seen), 32'(drop));
    endtask

    // Drive one cycle of stimulus, take the edge, and leave outputs settled for sampling.
    task automatic apply(input logic fl, input logic iv, input logic [7:0] d, input logic ord);
        flush     = fl;
        in_valid  = iv;
        data_in   = d;
        out_ready = ord;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        $display("t=%0t fl=%b iv=%b d=%h or=%b -> count=%0d ov=%b ir=%b dout=%h drop=%b",
                 $time, fl, iv, d, ord, count, out_valid, in_ready, data_out, drop_seen);
    endtask

    task automatic model_step(input logic fl, input logic iv, input logic [7:0] d, input logic ord);
        bit can_push, can_pop;
        can_push = (model_q.size() < 4);
        can_pop  = (model_q.size() > 0);
        if (iv && !can_push) model_drop = 1'b1;
        if (fl) begin
            model_q.delete();
        end else begin
            if (can_pop && ord) void'(model_q.pop_front());
            if (can_push && iv) model_q.push_back(d);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1, 1'b1, 1'b1, 8'hA5, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 8'h00, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'h01, 1'b0, 1, 1'b1, 1'b1, 8'h01, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'h02, 1'b0, 2, 1'b1, 1'b1, 8'h01, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'h03, 1'b0, 3, 1'b1, 1'b1, 8'h01, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'h04, 1'b0, 4, 1'b1, 1'b0, 8'h01, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'h05, 1'b0, 4, 1'b1, 1'b0, 8'h01, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3, 1'b1, 1'b1, 8'h02, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2, 1'b1, 1'b1, 8'h03, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b1, 8'h04, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 8'h00, 1'b1};

        rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = 8'h00;
        flush16 = 1'b0; in_valid16 = 1'b0; out_ready16 = 1'b0; data_in16 = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outs("reset", 0, 1'b0, 1'b1, 8'h00, 1'b0);

        // Single word, fill to full, dropped push, drain in order.
        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ord);
            check_outs($sformatf("tbl%0d", i), tbl[i].cnt, tbl[i].ov, tbl[i].ir,
                       tbl[i].dout, tbl[i].drop);
        end

        // Simultaneous push/pop at count=1, walking the pointers through several wraps.
        apply(1'b0, 1'b1, 8'h10, 1'b0);
        check_outs("pp_head", 1, 1'b1, 1'b1, 8'h10, 1'b1);
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b1, 8'(8'h20 + i), 1'b1);
            check_outs($sformatf("pp%0d", i), 1, 1'b1, 1'b1, 8'(8'h20 + i), 1'b1);
        end
        apply(1'b0, 1'b0, 8'h00, 1'b1);
        check_outs("pp_drain", 0, 1'b0, 1'b1, 8'h00, 1'b1);

        // Full with pop: ready stays low during the pop cycle, rises after.
        for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 8'(8'hB0 + i), 1'b0);
        check_outs("full", 4, 1'b1, 1'b0, 8'hB0, 1'b1);
        apply(1'b0, 1'b1, 8'hFF, 1'b1);
        check_outs("full_pop", 3, 1'b1, 1'b1, 8'hB1, 1'b1);

        // Flush beats concurrent push and pop; drop_seen survives it.
        apply(1'b1, 1'b1, 8'hEE, 1'b1);
        check_outs("flush", 0, 1'b0, 1'b1, 8'h00, 1'b1);

        // Asynchronous reset between edges at count=2.
        apply(1'b0, 1'b1, 8'hC1, 1'b0);
        apply(1'b0, 1'b1, 8'hC2, 1'b0);
        check_outs("pre_rst", 2, 1'b1, 1'b1, 8'hC1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 0, 1'b0, 1'b1, 8'h00, 1'b0);
        #2;
        rst_n = 1'b1;
        apply(1'b0, 1'b0, 8'h00, 1'b1);
        check_outs("post_rst", 0, 1'b0, 1'b1, 8'h00, 1'b0);

        // 16-bit instance.
        in_valid16 = 1'b1;
        data_in16  = 16'hBEEF;
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        $display("t=%0t w16 push BEEF -> count=%0d ov=%b dout=%h", $time, count16, out_valid16, data_out16);
        chk("w16.data_out",  32'(data_out16),  32'h0000BEEF);
        chk("w16.out_valid", 32'(out_valid16), 32'h1);
        chk("w16.count",     32'(count16),     32'h1);

        // Randomized run against the queue model.
        model_q.delete();
        model_drop = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic       fl, iv, ord;
            logic [7:0] d;
            fl  = ($urandom_range(0, 24) == 0);
            iv  = ($urandom_range(0, 99) < 60);
            ord = ($urandom_range(0, 99) < 45);
            d   = 8'($urandom);
            model_step(fl, iv, d, ord);
            apply(fl, iv, d, ord);
            check_outs($sformatf("rnd%0d", i), model_q.size(), model_q.size() > 0,
                       model_q.size() < 4, (model_q.size() > 0) ? model_q[0] : 8'h00, model_drop);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
